xfifo_rr_sched: RTL and testbench



---
 rtl/xfifo_rr_sched.sv | 102 ++++++++++
 tb/tb_xfifo_rr_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xfifo_rr_sched.sv
// Packet-aware round-robin drain of N XFifo queues onto one valid/ready link.
// Latency: 1 cycle from q_re to out_valid; 1 flit/cycle sustained.
// Backpressure: out_ready=0 with out_valid=1 holds the output flit and blocks all pops.
module xfifo_rr_sched #(
    parameter int N  = 4,
    parameter int DW = 8,
    localparam int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [N-1:0]    q_empty_n,
    input  logic [N*DW-1:0] q_dout,
    input  logic [N-1:0]    q_last,
    output logic [N-1:0]    q_re,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            out_last,
    output logic [SW-1:0]   out_src,
    output logic            busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] owner;

    logic          load;
    logic          grant_vld;
    logic [SW-1:0] grant;
    logic [DW-1:0] grant_data;
    logic          grant_last;
    logic [SW-1:0] grant_next;

    assign load = ~out_valid | out_ready;

    // While LOCKED only the owner may be popped, so packets never interleave.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant     = '0;
        if (!rst && en && load) begin
            if (state == LOCKED) begin
                grant_vld = q_empty_n[owner];
                grant     = owner;
            end else begin
                for (int k = 0; k < N; k++) begin
                    idx = int'(rr_ptr) + k;
                    if (idx >= N) idx = idx - N;
                    if (!grant_vld && q_empty_n[idx]) begin
                        grant_vld = 1'b1;
                        grant     = SW'(idx);
                    end
                end
            end
        end
    end

    assign q_re       = grant_vld ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;
    assign grant_data = q_dout[grant*DW +: DW];
    assign grant_last = q_last[grant];
    assign grant_next = (grant == SW'(N-1)) ? '0 : grant + 1'b1;
    assign busy       = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
        end else begin
            if (load) begin
                out_valid <= grant_vld;
                if (grant_vld) begin
                    out_data <= grant_data;
                    out_last <= grant_last;
                    out_src  <= grant;
                end
            end
            // Pointer advances only at packet end: fairness is per packet.
            if (grant_vld) begin
                if (grant_last) begin
                    state  <= IDLE;
                    rr_ptr <= grant_next;
                end else if (state == IDLE) begin
                    state <= LOCKED;
                    owner <= grant;
                end
            end
        end
    end

endmodule

// File: tb/tb_xfifo_rr_sched.sv
// Directed bench for xfifo_rr_sched: per-cycle vector table plus queue-model sequences.
// Latency/backpressure behaviour checked against hand-computed expectations.
// Inputs are driven after each posedge; outputs are sampled mid-cycle.
module tb_xfifo_rr_sched;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic          en;
    logic [N-1:0]  q_empty_n;
    logic [N*DW-1:0] q_dout;
    logic [N-1:0]  q_last;
    logic [N-1:0]  q_re;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    out_src;
    logic          busy;

    xfifo_rr_sched #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .q_empty_n (q_empty_n),
        .q_dout    (q_dout),
        .q_last    (q_last),
        .q_re      (q_re),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bench-side stand-in for the XFifo bank: {last, data} per entry.
    logic [8:0] qmem [N][16];
    int         wr [N];
    int         rd [N];
    bit         use_model;

    typedef struct packed {
        logic       en;
        logic       rdy;
        logic [3:0] ne;
        logic [3:0] last;
        logic [3:0] re;
        logic       ov;
        logic [7:0] od;
        logic       ol;
        logic [1:0] os;
        logic       busy;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_q();
        for (int i = 0; i < N; i++) begin
            q_empty_n[i]        = (rd[i] != wr[i]);
            q_dout[i*DW +: DW]  = qmem[i][rd[i] % 16][7:0];
            q_last[i]           = qmem[i][rd[i] % 16][8];
        end
    endtask

    task automatic push(input int q, input logic last, input logic [7:0] data);
        qmem[q][wr[q] % 16] = {last, data};
        wr[q]++;
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            wr[i] = 0;
            rd[i] = 0;
        end
    endtask

    // One clock: sample q_re just before the edge, pop the model, settle.
    task automatic tick();
        logic [3:0] re_s;
        #1;
        re_s = q_re;
        @(posedge clk);
        #1;
        if (use_model) begin
            for (int i = 0; i < N; i++)
                if (re_s[i]) rd[i]++;
            drive_q();
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_q();
        if (use_model) drive_q();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;
        q_empty_n = '0;
        q_dout    = '0;
        q_last    = '0;
        use_model = 1'b1;
        clear_q();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < 16; j++) qmem[i][j] = '0;
        drive_q();

        vecs[0]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 4'b1010, 4'b1111, 4'b0010, 1'b1, 8'h21, 1'b1, 2'd1, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 4'b1010, 4'b1111, 4'b1000, 1'b1, 8'h43, 1'b1, 2'd3, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 4'b1010, 4'b1111, 4'b0010, 1'b1, 8'h21, 1'b1, 2'd1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1, 8'h10, 1'b0, 2'd0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 4'b1110, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b1, 8'h10, 1'b0, 2'd0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1, 8'h10, 1'b0, 2'd0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 4'b1111, 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1, 2'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 4'b1111, 4'b1111, 4'b0010, 1'b1, 8'h21, 1'b1, 2'd1, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 4'b0000, 4'b1111, 4'b0000, 1'b1, 8'h21, 1'b1, 2'd1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 4'b0101, 4'b1111, 4'b0100, 1'b1, 8'h32, 1'b1, 2'd2, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 4'b0101, 4'b1111, 4'b0001, 1'b1, 8'h10, 1'b1, 2'd0, 1'b0};

        // Reset state, then 10 idle cycles with every queue empty.
        do_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_out_src",   32'(out_src),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        for (int c = 0; c < 10; c++) begin
            check("idle_q_re", 32'(q_re), 32'd0);
            tick();
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Per-cycle vector table with queue inputs driven directly.
        use_model = 1'b0;
        for (int v = 0; v < 15; v++) begin
            en        = vecs[v].en;
            out_ready = vecs[v].rdy;
            q_empty_n = vecs[v].ne;
            q_last    = vecs[v].last;
            q_dout    = 32'h43322110;
            #1;
            check($sformatf("vec%0d_q_re", v), 32'(q_re), 32'(vecs[v].re));
            tick();
            check($sformatf("vec%0d_out_valid", v), 32'(out_valid), 32'(vecs[v].ov));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
            if (vecs[v].ov) begin
                check($sformatf("vec%0d_out_data", v), 32'(out_data), 32'(vecs[v].od));
                check($sformatf("vec%0d_out_last", v), 32'(out_last), 32'(vecs[v].ol));
                check($sformatf("vec%0d_out_src", v), 32'(out_src), 32'(vecs[v].os));
            end
        end
        use_model = 1'b1;
        en        = 1'b1;
        out_ready = 1'b1;

        // Single-flit packets, two per queue: strict rotation at full rate.
        do_reset();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < N; i++) push(i, 1'b1, 8'(8'h80 + 16 * j + i));
        drive_q();
        #1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rr_q_re%0d", k), 32'(q_re), 32'(1 << (k % 4)));
            tick();
            check($sformatf("rr_valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("rr_src%0d", k), 32'(out_src), 32'(k % 4));
            check($sformatf("rr_data%0d", k), 32'(out_data), 32'(8'h80 + 16 * (k / 4) + (k % 4)));
        end
        check("rr_drained_q_re", 32'(q_re), 32'd0);
        tick();
        check("rr_drained_valid", 32'(out_valid), 32'd0);

        // Three-flit packet on q0 blocks q1 until its last flit leaves.
        do_reset();
        push(0, 1'b0, 8'hA0);
        push(0, 1'b0, 8'hA1);
        push(0, 1'b1, 8'hA2);
        push(1, 1'b1, 8'hB0);
        drive_q();
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("pkt_q_re%0d", k), 32'(q_re), (k < 3) ? 32'b0001 : 32'b0010);
            tick();
            check($sformatf("pkt_src%0d", k), 32'(out_src), (k < 3) ? 32'd0 : 32'd1);
            check($sformatf("pkt_data%0d", k), 32'(out_data), (k < 3) ? 32'(8'hA0 + k) : 32'hB0);
            check($sformatf("pkt_busy%0d", k), 32'(busy), (k < 2) ? 32'd1 : 32'd0);
        end

        // Owner runs dry mid-packet: q2 stays blocked, output goes idle.
        do_reset();
        push(0, 1'b0, 8'hC0);
        push(2, 1'b1, 8'hD0);
        drive_q();
        #1;
        check("starve_first_re", 32'(q_re), 32'b0001);
        tick();
        check("starve_first_data", 32'(out_data), 32'hC0);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("starve_q_re%0d", c), 32'(q_re), 32'd0);
            tick();
            check($sformatf("starve_valid%0d", c), 32'(out_valid), 32'd0);
            check($sformatf("starve_busy%0d", c), 32'(busy), 32'd1);
        end
        push(0, 1'b0, 8'hC1);
        push(0, 1'b1, 8'hC2);
        drive_q();
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("refill_q_re%0d", k), 32'(q_re), (k < 2) ? 32'b0001 : 32'b0100);
            tick();
            check($sformatf("refill_src%0d", k), 32'(out_src), (k < 2) ? 32'd0 : 32'd2);
            check($sformatf("refill_data%0d", k), 32'(out_data), (k < 2) ? 32'(8'hC1 + k) : 32'hD0);
        end

        // Backpressure: 4 stalled cycles hold A5, release pops the same cycle.
        do_reset();
        push(3, 1'b1, 8'hA5);
        push(3, 1'b1, 8'h5A);
        drive_q();
        tick();
        check("bp_first_data", 32'(out_data), 32'hA5);
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("bp_q_re%0d", c), 32'(q_re), 32'd0);
            tick();
            check($sformatf("bp_valid%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("bp_data%0d", c), 32'(out_data), 32'hA5);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_q_re", 32'(q_re), 32'b1000);
        tick();
        check("bp_release_data", 32'(out_data), 32'h5A);
        check("bp_release_src", 32'(out_src), 32'd3);

        // en=0 freezes the pointer: q2 pop leaves rr at 3, so q3 beats q1.
        do_reset();
        push(2, 1'b1, 8'hE2);
        drive_q();
        tick();
        check("en_pre_data", 32'(out_data), 32'hE2);
        en = 1'b0;
        push(1, 1'b1, 8'hE1);
        push(3, 1'b1, 8'hE3);
        drive_q();
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("en0_q_re%0d", c), 32'(q_re), 32'd0);
            tick();
            check($sformatf("en0_valid%0d", c), 32'(out_valid), 32'd0);
        end
        en = 1'b1;
        #1;
        check("en1_q_re", 32'(q_re), 32'b1000);
        tick();
        check("en1_src", 32'(out_src), 32'd3);
        tick();
        check("en1_next_src", 32'(out_src), 32'd1);

        // Reset mid-packet discards the lock and the pointer (rr was 2).
        push(0, 1'b0, 8'hF0);
        push(0, 1'b0, 8'hF1);
        push(0, 1'b1, 8'hF2);
        drive_q();
        tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_q_re", 32'(q_re), 32'd0);
        tick();
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        clear_q();
        push(1, 1'b1, 8'hF5);
        push(3, 1'b1, 8'hF7);
        drive_q();
        #1;
        check("post_rst_q_re", 32'(q_re), 32'b0010);
        tick();
        check("post_rst_src", 32'(out_src), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
